// File: rtl/rdback_sender_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rdback_sender_if
// Purpose  : Bundles the readback FIFO read port and the host transmit stream
//            seen by rdback_sender.
// Signals  : rdback_fifo_empty   FIFO empty flag
//            rdback_fifo_rden    FIFO read enable (data valid one cycle later)
//            rdback_fifo_rddata  FIFO read data, one DFI read beat
//            tx_data             host stream word
//            tx_valid            host stream word valid
//            tx_ready            host sink accepts the word
//            tx_last             marks the final word of a beat
//            tx_beat_cnt         count of fully transmitted beats (wrapping)
// Modports : master -> the sender; slave -> the FIFO/host environment.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface rdback_sender_if #(
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
);

  logic                    rdback_fifo_empty;
  logic                    rdback_fifo_rden;
  logic [4*DQ_WIDTH-1:0]   rdback_fifo_rddata;
  logic [OUT_WIDTH-1:0]    tx_data;
  logic                    tx_valid;
  logic                    tx_ready;
  logic                    tx_last;
  logic [31:0]             tx_beat_cnt;

  modport master (
    input  rdback_fifo_empty,
    input  rdback_fifo_rddata,
    input  tx_ready,
    output rdback_fifo_rden,
    output tx_data,
    output tx_valid,
    output tx_last,
    output tx_beat_cnt
  );

  modport slave (
    output rdback_fifo_empty,
    output rdback_fifo_rddata,
    output tx_ready,
    input  rdback_fifo_rden,
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    input  tx_beat_cnt
  );

endinterface : rdback_sender_if
`default_nettype wire

// File: rtl/rdback_sender.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rdback_sender
// Purpose  : Consumer end of the readback path. Pops DFI read beats
//            (4*DQ_WIDTH bits) from the readback FIFO and serializes each one
//            into N = 4*DQ_WIDTH/OUT_WIDTH words on a valid/ready stream,
//            least significant word first.
// Ports    : clk    - single block clock
//            rst_n  - synchronous active-low reset
//            bus    - rdback_sender_if.master (FIFO read port + host stream)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rdback_sender #(
  parameter int DQ_WIDTH  = 64,
  parameter int OUT_WIDTH = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rdback_sender_if.master   bus
);

  localparam int c_BEAT_W = 4 * DQ_WIDTH;
  localparam int c_N      = c_BEAT_W / OUT_WIDTH;
  localparam int c_IDX_W  = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N - 1);

  // Unsupported geometries are rejected at elaboration.
  generate
    if ((c_BEAT_W % OUT_WIDTH) != 0 || c_N < 2) begin : g_cfg_check
      $error("rdback_sender: 4*DQ_WIDTH must be a multiple of OUT_WIDTH with N >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t                 state_q;
  logic [c_BEAT_W-1:0]    hold_q;
  logic [c_IDX_W-1:0]     idx_q;
  logic [31:0]            tx_beat_cnt_q;
  logic                   tx_valid_q;
  logic [OUT_WIDTH-1:0]   tx_data_q;
  logic                   tx_last_q;

  logic [c_IDX_W-1:0]     idx_d;
  logic                   w_hs;
  logic                   w_last_hs;
  logic                   w_rden;
  logic [OUT_WIDTH-1:0]   w_words [c_N];

  // Slice the held beat into stream words; word 0 is the LSB slice.
  genvar gi;
  generate
    for (gi = 0; gi < c_N; gi++) begin : g_word
      assign w_words[gi] = hold_q[gi*OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign idx_d     = idx_q + 1'b1;
  // tx_valid is high exactly while in SEND, so the state stands in for it.
  assign w_hs      = (state_q == S_SEND) && bus.tx_ready;
  assign w_last_hs = w_hs && (idx_q == c_LAST_IDX);

  // Read enable: fetch from IDLE, or prefetch the next beat on the final
  // word handshake so only one bubble separates consecutive beats.
  always_comb begin
    w_rden = 1'b0;
    if (rst_n && !bus.rdback_fifo_empty) begin
      if (state_q == S_IDLE) begin
        w_rden = 1'b1;
      end else if (w_last_hs) begin
        w_rden = 1'b1;
      end
    end
  end

  // Stream outputs are registered and preloaded with the word that will be
  // visible in the next SEND cycle, so they never glitch while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      idx_q         <= '0;
      tx_beat_cnt_q <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      tx_last_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_rden) begin
            state_q <= S_LOAD;
          end
        end

        S_LOAD: begin
          hold_q     <= bus.rdback_fifo_rddata;
          idx_q      <= '0;
          state_q    <= S_SEND;
          tx_valid_q <= 1'b1;
          tx_data_q  <= bus.rdback_fifo_rddata[OUT_WIDTH-1:0];
          // N >= 2, so word 0 is never the last word.
          tx_last_q  <= 1'b0;
        end

        S_SEND: begin
          if (w_hs) begin
            if (idx_q != c_LAST_IDX) begin
              idx_q     <= idx_d;
              tx_data_q <= w_words[idx_d];
              tx_last_q <= (idx_d == c_LAST_IDX);
            end else begin
              tx_beat_cnt_q <= tx_beat_cnt_q + 32'd1;
              tx_valid_q    <= 1'b0;
              tx_data_q     <= '0;
              tx_last_q     <= 1'b0;
              state_q       <= w_rden ? S_LOAD : S_IDLE;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rdback_fifo_rden = w_rden;
  assign bus.tx_valid         = tx_valid_q;
  assign bus.tx_data          = tx_data_q;
  assign bus.tx_last          = tx_last_q;
  assign bus.tx_beat_cnt      = tx_beat_cnt_q;

endmodule : rdback_sender
`default_nettype wire

// File: tb/tb_rdback_sender.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rdback_sender
// Purpose  : Self-checking bench for rdback_sender. A queue-based FIFO model
//            feeds the DUT; a word-level scoreboard holds the expected stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rdback_sender;

  localparam int DQ_WIDTH  = 64;
  localparam int OUT_WIDTH = 32;
  localparam int BEAT_W    = 4 * DQ_WIDTH;
  localparam int N         = BEAT_W / OUT_WIDTH;

  typedef struct {
    logic [OUT_WIDTH-1:0] d;
    int                   k;
  } word_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rdback_sender_if #(.DQ_WIDTH(DQ_WIDTH), .OUT_WIDTH(OUT_WIDTH)) bus ();

  rdback_sender #(.DQ_WIDTH(DQ_WIDTH), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [BEAT_W-1:0]    fifo_q [$];
  word_t                exp_q  [$];
  int                   hs_cyc [$];
  int                   rden_cyc [$];
  int                   cyc = 0;
  logic                 rden_s = 1'b0;
  logic                 rand_ready = 1'b0;
  logic                 ready_fixed = 1'b0;
  logic [31:0]          exp_beats = 32'd0;
  logic                 prev_stall = 1'b0;
  logic [OUT_WIDTH-1:0] prev_data = '0;
  logic                 prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO and sink model: updates just after each rising edge.
  initial begin
    bus.rdback_fifo_empty  = 1'b1;
    bus.rdback_fifo_rddata = '0;
    bus.tx_ready           = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rden_s) begin
        check("rden_when_empty", 64'(fifo_q.size() > 0), 64'd1);
        if (fifo_q.size() > 0) bus.rdback_fifo_rddata = fifo_q.pop_front();
      end
      bus.rdback_fifo_empty = (fifo_q.size() == 0);
      bus.tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : ready_fixed;
    end
  end

  // Stream monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    word_t w;
    cyc++;
    rden_s = bus.rdback_fifo_rden;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.rdback_fifo_rden) rden_cyc.push_back(cyc);
      if (prev_stall) begin
        check("stall_valid", 64'(bus.tx_valid), 64'd1);
        check("stall_data", 64'(bus.tx_data), 64'(prev_data));
        check("stall_last", 64'(bus.tx_last), 64'(prev_last));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("spurious_word", 64'(exp_q.size()), 64'd1);
        end else begin
          w = exp_q.pop_front();
          check("word_data", 64'(bus.tx_data), 64'(w.d));
          check("word_last", 64'(bus.tx_last), 64'(w.k == N - 1));
          if (w.k == N - 1) exp_beats = exp_beats + 32'd1;
        end
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
      prev_last  = bus.tx_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input logic [BEAT_W-1:0] b);
    word_t w;
    fifo_q.push_back(b);
    for (int k = 0; k < N; k++) begin
      w.d = b[k*OUT_WIDTH +: OUT_WIDTH];
      w.k = k;
      exp_q.push_back(w);
    end
  endtask

  function automatic logic [BEAT_W-1:0] ramp_beat();
    logic [BEAT_W-1:0] b = '0;
    for (int k = 0; k < N; k++) b[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(k);
    return b;
  endfunction

  function automatic logic [BEAT_W-1:0] rand_beat();
    logic [BEAT_W-1:0] b = '0;
    for (int i = 0; i < BEAT_W / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0 || bus.tx_valid) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_gaps(input string tag, input int beats);
    check({tag, "_hs_count"}, 64'(hs_cyc.size()), 64'(beats * N));
    if (hs_cyc.size() == beats * N) begin
      for (int i = 1; i < beats * N; i++) begin
        check({tag, "_gap"}, 64'(hs_cyc[i] - hs_cyc[i-1]), (i % N == 0) ? 64'd2 : 64'd1);
      end
    end
  endtask

  initial begin
    // Reset held with a non-empty FIFO: nothing may move.
    fifo_q.push_back('1);
    rst_n = 1'b0;
    repeat (5) begin
      tick();
      check("rst_rden", 64'(bus.rdback_fifo_rden), 64'd0);
      check("rst_valid", 64'(bus.tx_valid), 64'd0);
      check("rst_cnt", 64'(bus.tx_beat_cnt), 64'd0);
    end
    check("rst_last", 64'(bus.tx_last), 64'd0);
    check("rst_data", 64'(bus.tx_data), 64'd0);
    fifo_q.delete();
    tick();
    rst_n = 1'b1;
    exp_beats = 32'd0;
    repeat (3) begin
      tick();
      check("idle_rden", 64'(bus.rdback_fifo_rden), 64'd0);
      check("idle_valid", 64'(bus.tx_valid), 64'd0);
    end

    // Single ramp beat with the sink always ready.
    ready_fixed = 1'b1;
    tick();
    hs_cyc.delete();
    rden_cyc.delete();
    push_beat(ramp_beat());
    drain("single");
    check("single_rden_count", 64'(rden_cyc.size()), 64'd1);
    check_gaps("single", 1);
    if (rden_cyc.size() > 0 && hs_cyc.size() > 0)
      check("single_latency", 64'(hs_cyc[0] - rden_cyc[0]), 64'd2);
    check("single_cnt", 64'(bus.tx_beat_cnt), 64'd1);

    // Three beats back to back.
    hs_cyc.delete();
    rden_cyc.delete();
    repeat (3) push_beat(rand_beat());
    drain("b2b");
    check("b2b_rden_count", 64'(rden_cyc.size()), 64'd3);
    check_gaps("b2b", 3);
    check("b2b_cnt", 64'(bus.tx_beat_cnt), 64'd4);

    // Random backpressure over four beats.
    hs_cyc.delete();
    rden_cyc.delete();
    rand_ready = 1'b1;
    repeat (4) push_beat(rand_beat());
    drain("bp");
    rand_ready = 1'b0;
    tick();
    check("bp_rden_count", 64'(rden_cyc.size()), 64'd4);
    check("bp_hs_count", 64'(hs_cyc.size()), 64'(4 * N));
    check("bp_cnt", 64'(bus.tx_beat_cnt), 64'(exp_beats));

    // Reset just after word 3 of a beat is accepted.
    tick();
    hs_cyc.delete();
    rden_cyc.delete();
    push_beat(rand_beat());
    push_beat(rand_beat());
    for (int n = 0; n < 200 && hs_cyc.size() < 4; n++) tick();
    check("mid_words_before_rst", 64'(hs_cyc.size()), 64'd4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 64'(bus.tx_valid), 64'd0);
    check("mid_rst_cnt", 64'(bus.tx_beat_cnt), 64'd0);
    check("mid_rst_rden", 64'(bus.rdback_fifo_rden), 64'd0);
    while (exp_q.size() > 0 && exp_q[0].k != 0) void'(exp_q.pop_front());
    exp_beats = 32'd0;
    rst_n = 1'b1;
    drain("mid");
    check("mid_rden_count", 64'(rden_cyc.size()), 64'd2);
    check("mid_cnt", 64'(bus.tx_beat_cnt), 64'd1);

    // Counter wrap from all ones.
    tick();
    dut.tx_beat_cnt_q = 32'hFFFF_FFFF;
    exp_beats = 32'hFFFF_FFFF;
    tick();
    check("wrap_preload", 64'(bus.tx_beat_cnt), 64'hFFFF_FFFF);
    push_beat(rand_beat());
    drain("wrap");
    check("wrap_cnt", 64'(bus.tx_beat_cnt), 64'd0);
    check("wrap_model_cnt", 64'(bus.tx_beat_cnt), 64'(exp_beats));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_rdback_sender
`default_nettype wire

// File: doc/rdback_sender.md
# rdback_sender

Drains the readback FIFO that the read-capture path fills with DFI read beats. Each stored beat is 4*DQ_WIDTH bits. The block serializes every beat into OUT_WIDTH-bit words on a valid/ready stream toward the host link. It sits between the readback FIFO read port and the host transmit channel, and it is the consumer end of the readback path.

## Interface
Parameters:
- DQ_WIDTH, 64: DRAM data bus width; one FIFO entry is 4*DQ_WIDTH bits.
- OUT_WIDTH, 32: host stream word width. 4*DQ_WIDTH must be an integer multiple of OUT_WIDTH. N = 4*DQ_WIDTH/OUT_WIDTH must be at least 2; other configurations are unsupported.

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  synchronous, active-low reset.
- rdback_fifo_empty  in  1  FIFO empty flag.
- rdback_fifo_rden  out  1  FIFO read enable. Standard FIFO: data appears one cycle after rden.
- rdback_fifo_rddata  in  4*DQ_WIDTH  FIFO read data.
- tx_data  out  OUT_WIDTH  stream word.
- tx_valid  out  1  stream word valid.
- tx_ready  in  1  sink accepts the word.
- tx_last  out  1  marks word N-1 of a beat.
- tx_beat_cnt  out  32  count of fully transmitted beats; wraps modulo 2^32.

## Operation
- The FSM has three states: IDLE, LOAD, SEND. Registers:
  - hold_r: 4*DQ_WIDTH-bit beat register.
  - idx_r: word index, clog2(N) bits.
  - tx_beat_cnt.
- rdback_fifo_rden is combinational and forced to 0 while rst_n=0. It is 1 in two cases:
  - state==IDLE and !rdback_fifo_empty.
  - state==SEND, tx_valid&tx_ready, idx_r==N-1, and !rdback_fifo_empty. This prefetches the next beat.
- IDLE:
  - If rden=1, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - Capture hold_r <= rdback_fifo_rddata.
  - Set idx_r <= 0.
  - Go to SEND.
- SEND:
  - tx_valid=1.
  - tx_data = hold_r[idx_r*OUT_WIDTH +: OUT_WIDTH]. Word 0 is the least significant slice and is sent first.
  - tx_last = (idx_r==N-1).
  - On handshake with idx_r<N-1: idx_r increments.
  - On handshake with idx_r==N-1: tx_beat_cnt increments. The next state is LOAD if rden=1 this cycle, otherwise IDLE.
  - Without a handshake, all state holds.
- tx_valid=0 in IDLE and LOAD. tx_data and tx_last are don't-care when tx_valid=0, but are driven to 0 for determinism.
- Stream rule: once tx_valid rises, tx_data, tx_last and tx_valid stay stable until the handshake. tx_valid never drops without a handshake except on reset.
- Exactly one rden pulse is issued per FIFO entry. rden is never asserted while empty=1.
- Empty toggling during SEND has no effect until the last-word handshake.
- tx_ready may be asserted before tx_valid; this is legal and has no effect.

## Timing
- Reset values:
  - state=IDLE, idx_r=0, hold_r=0, tx_beat_cnt=0.
  - tx_valid=0, tx_last=0, tx_data=0, rdback_fifo_rden=0.
- Reset mid-operation: the next edge with rst_n=0 returns the block to reset values.
  - The partially sent beat is discarded.
  - FIFO contents are untouched; the FIFO has its own reset.
- Latency: empty falls at cycle t, so rden=1 at t, LOAD at t+1, and tx_valid with word 0 at t+2.
- Throughput with tx_ready held high:
  - Words 0..N-1 go out at t+2..t+N+1.
  - Prefetch rden fires at t+N+1.
  - The next beat's word 0 appears at t+N+3.
  - There is one idle stream cycle per beat, giving an efficiency of N/(N+1).
- tx_beat_cnt updates on the edge after the last-word handshake. It wraps from 0xFFFFFFFF to 0.

## Test plan
- Reset/idle: hold rst_n=0 for 5 cycles with empty=0.
  - Required: rden=0, tx_valid=0, tx_beat_cnt=0 throughout.
  - After release, hold empty=1: rden stays 0.
- Single beat, default parameters (N=8): FIFO holds one entry 0x...0007_0006_..._0001_0000 (word k = k), tx_ready=1.
  - rden pulses once.
  - Words 0..7 appear on consecutive cycles starting 2 cycles after rden.
  - tx_last is set only on word 7.
  - tx_beat_cnt becomes 1.
- Back-to-back: 3 entries queued, tx_ready=1.
  - 24 words with exactly one bubble between beats.
  - 3 rden pulses.
  - tx_beat_cnt=3.
  - Data order is preserved.
- Backpressure: tx_ready toggles with a random pattern (about 30% high) over 4 beats.
  - tx_data and tx_last stay stable while valid&!ready.
  - No word is dropped or duplicated.
  - The output matches the FIFO contents in order.
- Reset mid-beat: assert rst_n=0 for 1 cycle after word 3 of a beat is accepted.
  - tx_valid=0 on the next cycle.
  - tx_beat_cnt=0.
  - The next FIFO entry is then sent from word 0 with a correct rden count.
- Counter wrap: force tx_beat_cnt to 0xFFFFFFFF via hierarchical preload, then send one beat.
  - Required: tx_beat_cnt=0.
